// File: rtl/serial_stream_in.sv
// 8N1 UART receiver with a byte FIFO that feeds the terminal stream decoder.
// Bytes are released one at a time under the decoder's active-low ready_n handshake.
module serial_stream_in #(
    parameter int unsigned CLOCKS_PER_BIT  = 434,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4,
    parameter int unsigned RTS_THRESHOLD   = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       ready_n,
    output logic [7:0] unicode,
    output logic       unicode_available,
    output logic       rts_n,
    output logic       overflow,
    output logic       frame_error
);

    localparam int unsigned Depth = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned CntW  = $clog2(CLOCKS_PER_BIT);
    localparam int unsigned FillW = FIFO_DEPTH_LOG2 + 1;

    localparam logic [CntW-1:0]  HalfBit  = CntW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0]  FullBit  = CntW'(CLOCKS_PER_BIT - 1);
    localparam logic [FillW-1:0] FullFill = FillW'(Depth);
    localparam logic [FillW-1:0] RtsFill  = FillW'(RTS_THRESHOLD);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic {OutWait, OutStrobe} out_state_e;

    logic                       rx_meta_q, rxs_q;
    rx_state_e                  rx_state_q, rx_state_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [2:0]                 idx_q, idx_d;
    logic [7:0]                 shift_q, shift_d;
    logic                       push, pop, full;
    logic                       overflow_q, overflow_d;
    logic                       frame_error_q, frame_error_d;

    logic [7:0]                 mem_q [Depth];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [FillW-1:0]           fill_q, fill_d;

    out_state_e                 out_state_q, out_state_d;
    logic [7:0]                 unicode_q, unicode_d;
    logic                       avail_q, avail_d;
    logic                       rts_n_q, rts_n_d;

    // Synchroniser flops reset to the idle line level so reset never fakes a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    assign full = (fill_q == FullFill);

    always_comb begin
        rx_state_d    = rx_state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        push          = 1'b0;
        overflow_d    = 1'b0;
        frame_error_d = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                if (!rxs_q) begin
                    rx_state_d = RxStart;
                    cnt_d      = HalfBit;
                end
            end
            RxStart: begin
                if (cnt_q == '0) begin
                    if (!rxs_q) begin
                        rx_state_d = RxData;
                        cnt_d      = FullBit;
                        idx_d      = 3'd0;
                    end else begin
                        rx_state_d = RxIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RxData: begin
                if (cnt_q == '0) begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    cnt_d   = FullBit;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) rx_state_d = RxStop;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RxStop: begin
                // Returning to idle at mid-stop-bit leaves half a bit to catch the next start.
                if (cnt_q == '0) begin
                    rx_state_d = RxIdle;
                    if (!rxs_q)    frame_error_d = 1'b1;
                    else if (full) overflow_d    = 1'b1;
                    else           push          = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    assign pop = (out_state_q == OutWait) && !ready_n && (fill_q != '0);

    always_comb begin
        fill_d = fill_q;
        case ({push, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    always_comb begin
        out_state_d = out_state_q;
        unicode_d   = unicode_q;
        avail_d     = 1'b0;
        case (out_state_q)
            OutWait: begin
                if (pop) begin
                    unicode_d   = mem_q[rd_ptr_q];
                    avail_d     = 1'b1;
                    out_state_d = OutStrobe;
                end
            end
            // Mandatory gap cycle lets the decoder's registered ready_n settle.
            OutStrobe: out_state_d = OutWait;
            default:   out_state_d = OutWait;
        endcase
    end

    assign rts_n_d = (fill_d >= RtsFill);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q    <= RxIdle;
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            shift_q       <= 8'h00;
            overflow_q    <= 1'b0;
            frame_error_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fill_q        <= '0;
            out_state_q   <= OutWait;
            unicode_q     <= 8'h00;
            avail_q       <= 1'b0;
            rts_n_q       <= 1'b1;
        end else begin
            rx_state_q    <= rx_state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            overflow_q    <= overflow_d;
            frame_error_q <= frame_error_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            fill_q        <= fill_d;
            out_state_q   <= out_state_d;
            unicode_q     <= unicode_d;
            avail_q       <= avail_d;
            rts_n_q       <= rts_n_d;
        end
    end

    assign unicode           = unicode_q;
    assign unicode_available = avail_q;
    assign rts_n             = rts_n_q;
    assign overflow          = overflow_q;
    assign frame_error       = frame_error_q;

endmodule

// File: tb/tb_serial_stream_in.sv
// Directed bench for serial_stream_in at 8 clocks per bit, 16-entry FIFO, RTS level 12.
module tb_serial_stream_in;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       tb_ready_n = 1'b0;
    logic       dec_en = 1'b0;
    int         dec_busy = 0;
    logic       ready_n;
    logic [7:0] unicode;
    logic       unicode_available, rts_n, overflow, frame_error;

    int checks = 0;
    int passed = 0;

    // Observation queues filled at every strobe
    logic [7:0] q_data [$];
    int         q_cyc [$];
    logic       q_rts [$];
    int         cyc = 0;
    int         bad_strobe = 0;
    int         ovf_cnt = 0;
    int         ferr_cnt = 0;
    logic       rdy_sampled = 1'b0;

    assign ready_n = dec_en ? (dec_busy != 0) : tb_ready_n;

    serial_stream_in #(
        .CLOCKS_PER_BIT (8),
        .FIFO_DEPTH_LOG2(4),
        .RTS_THRESHOLD  (12)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rx               (rx),
        .ready_n          (ready_n),
        .unicode          (unicode),
        .unicode_available(unicode_available),
        .rts_n            (rts_n),
        .overflow         (overflow),
        .frame_error      (frame_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rdy_sampled <= ready_n;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (unicode_available === 1'b1) begin
            q_data.push_back(unicode);
            q_cyc.push_back(cyc);
            q_rts.push_back(rts_n);
            if (rdy_sampled !== 1'b0) bad_strobe <= bad_strobe + 1;
        end
        if (overflow === 1'b1)    ovf_cnt  <= ovf_cnt + 1;
        if (frame_error === 1'b1) ferr_cnt <= ferr_cnt + 1;
    end

    // Decoder model: busy for 50 cycles after each consumed byte
    always @(negedge clk) begin
        if (!dec_en)                        dec_busy <= 0;
        else if (unicode_available === 1'b1) dec_busy <= 50;
        else if (dec_busy != 0)             dec_busy <= dec_busy - 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        tick(8);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(8);
        end
        rx = stop;
        tick(8);
        rx = 1'b1;
    endtask

    task automatic clear_obs();
        q_data.delete();
        q_cyc.delete();
        q_rts.delete();
        bad_strobe = 0;
        ovf_cnt = 0;
        ferr_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++;
        if (unicode !== 8'h00) $display("FAIL reset_unicode: got %h required 00", unicode);
        else passed++;
        checks++;
        if (unicode_available !== 1'b0) $display("FAIL reset_avail: got %b required 0", unicode_available);
        else passed++;
        checks++;
        if (rts_n !== 1'b1) $display("FAIL reset_rts_n: got %b required 1", rts_n);
        else passed++;
        checks++;
        if (overflow !== 1'b0 || frame_error !== 1'b0)
            $display("FAIL reset_errs: got %b%b required 00", overflow, frame_error);
        else passed++;
        reset = 1'b0;
        tick(1);
        checks++;
        if (rts_n !== 1'b0) $display("FAIL post_reset_rts_n: got %b required 0", rts_n);
        else passed++;
    endtask

    task automatic test_single_byte();
        tb_ready_n = 1'b0;
        clear_obs();
        send_frame(8'h41, 1'b1);
        checks++;
        if (unicode_available !== 1'b1 || unicode !== 8'h41)
            $display("FAIL single_strobe: got avail=%b data=%h required avail=1 data=41",
                     unicode_available, unicode);
        else passed++;
        tick(1);
        checks++;
        if (unicode_available !== 1'b0) $display("FAIL single_width: got %b required 0", unicode_available);
        else passed++;
        tick(10);
        checks++;
        if (q_data.size() != 1 || ovf_cnt != 0 || ferr_cnt != 0)
            $display("FAIL single_counts: got strobes=%0d ovf=%0d ferr=%0d required 1 0 0",
                     q_data.size(), ovf_cnt, ferr_cnt);
        else passed++;
    endtask

    task automatic test_glitch();
        clear_obs();
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(20);
        checks++;
        if (q_data.size() != 0) $display("FAIL glitch_no_byte: got %0d strobes required 0", q_data.size());
        else passed++;
        send_frame(8'h0A, 1'b1);
        checks++;
        if (unicode_available !== 1'b1 || unicode !== 8'h0A)
            $display("FAIL glitch_next_byte: got avail=%b data=%h required avail=1 data=0a",
                     unicode_available, unicode);
        else passed++;
        tick(10);
    endtask

    task automatic test_frame_error();
        clear_obs();
        send_frame(8'h55, 1'b0);
        tick(20);
        checks++;
        if (ferr_cnt != 1) $display("FAIL frame_error_pulse: got %0d pulses required 1", ferr_cnt);
        else passed++;
        checks++;
        if (q_data.size() != 0 || ovf_cnt != 0)
            $display("FAIL frame_error_dropped: got strobes=%0d ovf=%0d required 0 0",
                     q_data.size(), ovf_cnt);
        else passed++;
    endtask

    task automatic test_overflow();
        int n;
        clear_obs();
        tb_ready_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_frame(8'(i), 1'b1);
            checks++;
            if (rts_n !== (i >= 11))
                $display("FAIL fill_rts_n[%0d]: got %b required %b", i, rts_n, (i >= 11));
            else passed++;
        end
        send_frame(8'h10, 1'b1);
        tick(2);
        checks++;
        if (ovf_cnt != 1 || q_data.size() != 0)
            $display("FAIL overflow_pulse: got ovf=%0d strobes=%0d required 1 0", ovf_cnt, q_data.size());
        else passed++;
        tb_ready_n = 1'b0;
        n = 0;
        while (q_data.size() < 16 && n < 100) begin
            tick(1);
            n++;
        end
        tick(5);
        checks++;
        if (q_data.size() != 16) $display("FAIL drain_count: got %0d required 16", q_data.size());
        else passed++;
        for (int k = 0; k < 16 && k < q_data.size(); k++) begin
            checks++;
            if (q_data[k] !== 8'(k)) $display("FAIL drain_data[%0d]: got %h required %h", k, q_data[k], 8'(k));
            else passed++;
            checks++;
            if (q_rts[k] !== ((15 - k) >= 12))
                $display("FAIL drain_rts_n[%0d]: got %b required %b", k, q_rts[k], ((15 - k) >= 12));
            else passed++;
            if (k > 0) begin
                checks++;
                if (q_cyc[k] - q_cyc[k-1] != 2)
                    $display("FAIL drain_spacing[%0d]: got %0d required 2", k, q_cyc[k] - q_cyc[k-1]);
                else passed++;
            end
        end
        tick(10);
    endtask

    task automatic test_back_to_back();
        int n;
        logic [7:0] exp;
        clear_obs();
        dec_en = 1'b1;
        for (int i = 0; i < 5; i++) send_frame(8'hA1 + 8'(i), 1'b1);
        n = 0;
        while (q_data.size() < 5 && n < 400) begin
            tick(1);
            n++;
        end
        tick(60);
        checks++;
        if (q_data.size() != 5) $display("FAIL b2b_count: got %0d required 5", q_data.size());
        else passed++;
        for (int k = 0; k < 5 && k < q_data.size(); k++) begin
            exp = 8'hA1 + 8'(k);
            checks++;
            if (q_data[k] !== exp) $display("FAIL b2b_data[%0d]: got %h required %h", k, q_data[k], exp);
            else passed++;
        end
        checks++;
        if (bad_strobe != 0 || ovf_cnt != 0)
            $display("FAIL b2b_handshake: got busy_strobes=%0d ovf=%0d required 0 0", bad_strobe, ovf_cnt);
        else passed++;
        dec_en = 1'b0;
        tick(5);
    endtask

    task automatic test_reset_midframe();
        clear_obs();
        tb_ready_n = 1'b1;
        send_frame(8'h31, 1'b1);
        send_frame(8'h32, 1'b1);
        send_frame(8'h33, 1'b1);
        rx = 1'b0;
        tick(8);
        rx = 1'b1;
        tick(12);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if (unicode !== 8'h00 || unicode_available !== 1'b0)
            $display("FAIL midreset_out: got data=%h avail=%b required 00 0", unicode, unicode_available);
        else passed++;
        checks++;
        if (rts_n !== 1'b1 || overflow !== 1'b0 || frame_error !== 1'b0)
            $display("FAIL midreset_flags: got rts_n=%b ovf=%b ferr=%b required 1 0 0",
                     rts_n, overflow, frame_error);
        else passed++;
        tick(1);
        checks++;
        if (rts_n !== 1'b0) $display("FAIL midreset_rts_n: got %b required 0", rts_n);
        else passed++;
        tb_ready_n = 1'b0;
        tick(20);
        checks++;
        if (q_data.size() != 0) $display("FAIL midreset_empty: got %0d strobes required 0", q_data.size());
        else passed++;
        send_frame(8'h7E, 1'b1);
        checks++;
        if (unicode_available !== 1'b1 || unicode !== 8'h7E)
            $display("FAIL midreset_next: got avail=%b data=%h required avail=1 data=7e",
                     unicode_available, unicode);
        else passed++;
        tick(5);
    endtask

    initial begin
        test_reset();
        tick(5);
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_overflow();
        test_back_to_back();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
